// File: rtl/pulse_recovery_pkg.sv
// Shared types for the pulse recovery block: FSM state type and run-counter sizing.
package pulse_recovery_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_HIGH    = 3'd2,
        ST_STUCK   = 3'd3,
        ST_REARM   = 3'd4
    } state_t;

    // The run counter must reach both the stuck threshold and the re-arm threshold.
    function automatic int run_cnt_width(input int max_high, input int min_low);
        int top;
        top = (max_high > min_low) ? max_high : min_low;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/pulse_recovery_bit_synchronizer.sv
// N-flop synchroniser for a single asynchronous bit; output is the last stage.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], d};
        end
    end

    assign q = sync_p0[STAGES-1];

endmodule

// File: rtl/pulse_recovery.sv
// Recovers one single-cycle event per qualified high run of a stretched input,
// flagging short runs as glitches and over-long runs as stuck.
module pulse_recovery
    import pulse_recovery_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 4,
    parameter int MAX_HIGH    = 12,
    parameter int MIN_LOW     = 2,
    parameter int PCNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_in,
    output logic                  pulse,
    output logic                  glitch,
    output logic                  stuck_err,
    output logic                  busy,
    output logic [PCNT_WIDTH-1:0] pulse_count
);

    localparam int CNT_W = run_cnt_width(MAX_HIGH, MIN_LOW);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] MIN_LOW_C  = CNT_W'(MIN_LOW);
    localparam logic [PCNT_WIDTH-1:0] PCNT_ONE = PCNT_WIDTH'(1);
    localparam bit   MIN_HIGH_ONE = (MIN_HIGH == 1);
    localparam bit   MIN_LOW_ONE  = (MIN_LOW == 1);

    if (MIN_HIGH < 1 || MIN_HIGH >= MAX_HIGH || MIN_LOW < 1 || SYNC_STAGES < 2) begin : g_bad_params
        $error("pulse_recovery: illegal parameter combination");
    end

    logic             sig_p0;
    state_t           state_p1, state_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_nxt, cnt_inc;
    logic             pulse_nxt, glitch_nxt, stuck_nxt;

    // Stage 0: bring signal_in into the clk domain
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal_in),
        .q     (sig_p0)
    );

    // Stage 1: run qualification on the synchronised level
    assign cnt_inc = (cnt_p1 == CNT_MAX) ? cnt_p1 : cnt_p1 + CNT_ONE;

    always_comb begin
        state_nxt  = state_p1;
        cnt_nxt    = cnt_p1;
        pulse_nxt  = 1'b0;
        glitch_nxt = 1'b0;
        stuck_nxt  = 1'b0;
        case (state_p1)
            ST_IDLE: begin
                if (sig_p0) begin
                    cnt_nxt = CNT_ONE;
                    if (MIN_HIGH_ONE) begin
                        state_nxt = ST_HIGH;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (!sig_p0) begin
                    state_nxt  = ST_IDLE;
                    glitch_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == MIN_HIGH_C) begin
                        state_nxt = ST_HIGH;
                        pulse_nxt = 1'b1;
                    end
                end
            end
            ST_HIGH, ST_STUCK: begin
                if (!sig_p0) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = MIN_LOW_ONE ? ST_IDLE : ST_REARM;
                end else if (state_p1 == ST_HIGH) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == MAX_HIGH_C) begin
                        state_nxt = ST_STUCK;
                        stuck_nxt = 1'b1;
                    end
                end
            end
            ST_REARM: begin
                if (sig_p0) begin
                    // a bounce re-enters the accepted run without a new event
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == MIN_LOW_C) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage 2: registered state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1    <= ST_IDLE;
            cnt_p1      <= '0;
            pulse       <= 1'b0;
            glitch      <= 1'b0;
            stuck_err   <= 1'b0;
            busy        <= 1'b0;
            pulse_count <= '0;
        end else begin
            state_p1  <= state_nxt;
            cnt_p1    <= cnt_nxt;
            pulse     <= pulse_nxt;
            glitch    <= glitch_nxt;
            stuck_err <= stuck_nxt;
            busy      <= (state_nxt != ST_IDLE);
            if (pulse_nxt) begin
                pulse_count <= pulse_count + PCNT_ONE;
            end
        end
    end

endmodule
